// File: rtl/dmux_stream_1n.sv
// dmux_stream_1n: registered 1-to-NCH valid/ready stream demultiplexer.
// Each input word goes either to one selected channel (unicast) or to every
// channel (broadcast). Every channel has a one-entry output register, which
// gives one cycle of latency and full throughput under back-pressure.
// Unicast words addressed past the last channel are dropped and counted in
// a saturating counter.
module dmux_stream_1n #(
    parameter int DW  = 8,
    parameter int NCH = 4,
    parameter int CW  = 8,
    localparam int SW = $clog2(NCH)
) (
    input  logic              iclk,
    input  logic              irst_n,
    input  logic              ivalid,
    output logic              oready,
    input  logic [DW-1:0]     idata,
    input  logic [SW-1:0]     isel,
    input  logic              ibcast,
    output logic [NCH-1:0]    ovalid,
    output logic [NCH*DW-1:0] odata,
    input  logic [NCH-1:0]    iready,
    output logic [CW-1:0]     odrop_cnt
);

    localparam int unsigned NCHU = NCH;

    logic [NCH-1:0]    vld_q;
    logic [NCH*DW-1:0] data_q;
    logic [CW-1:0]     drop_q;

    logic [NCH-1:0]    free;
    logic [NCH-1:0]    sel_hit;
    logic [NCH-1:0]    load;
    logic              sel_ok;
    logic              xfer;
    logic              drop;

    // Acceptance decision: which channels take the word, or whether it is dropped.
    always_comb begin
        free    = ~vld_q | iready;
        sel_hit = '0;
        for (int unsigned k = 0; k < NCHU; k++) begin
            sel_hit[k] = (32'(isel) == k);
        end
        // Only reachable when NCH is not a power of two.
        sel_ok = (32'(isel) < NCHU);

        if (ibcast) begin
            oready = &free;
        end else if (sel_ok) begin
            oready = |(free & sel_hit);
        end else begin
            oready = 1'b1;
        end

        xfer = ivalid & oready;
        if (ibcast) begin
            load = {NCH{xfer}};
        end else begin
            load = sel_hit & {NCH{xfer}};
        end
        drop = xfer & ~ibcast & ~sel_ok;
    end

    // Per-channel output register: a refill wins over a drain, so a channel
    // that is read and written in the same cycle stays valid with no bubble.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            vld_q  <= '0;
            data_q <= '0;
        end else begin
            for (int unsigned k = 0; k < NCHU; k++) begin
                if (load[k]) begin
                    vld_q[k]             <= 1'b1;
                    data_q[k*DW +: DW]   <= idata;
                end else if (vld_q[k] && iready[k]) begin
                    vld_q[k]             <= 1'b0;
                    data_q[k*DW +: DW]   <= '0;
                end
            end
        end
    end

    // Saturating count of unicast words addressed to a non-existent channel.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            drop_q <= '0;
        end else if (drop && (drop_q != '1)) begin
            drop_q <= drop_q + 1'b1;
        end
    end

    assign ovalid    = vld_q;
    assign odata     = data_q;
    assign odrop_cnt = drop_q;

endmodule

// File: tb/tb_dmux_stream_1n.sv
// tb_dmux_stream_1n: directed and random checks for dmux_stream_1n.
// A 4-channel instance is tracked by a queue-per-channel scoreboard; a
// 3-channel instance with a 2-bit counter exercises drops and saturation.
module tb_dmux_stream_1n;

    logic        iclk = 1'b0;
    logic        irst_n;

    logic        ivalid;
    logic        oready;
    logic [7:0]  idata;
    logic [1:0]  isel;
    logic        ibcast;
    logic [3:0]  ovalid;
    logic [31:0] odata;
    logic [3:0]  iready;
    logic [7:0]  odrop_cnt;

    logic        v3;
    logic        r3o;
    logic [7:0]  d3;
    logic [1:0]  s3;
    logic        b3;
    logic [2:0]  ov3;
    logic [23:0] od3;
    logic [2:0]  rdy3;
    logic [1:0]  cnt3;

    int errors = 0;
    int checks = 0;

    // Words accepted but not yet consumed, per channel, oldest first.
    logic [7:0] exp_q [4][$];
    // Model occupancy of each channel for the current cycle.
    bit         held [4];

    dmux_stream_1n #(.DW(8), .NCH(4), .CW(8)) u_dut (
        .iclk      (iclk),
        .irst_n    (irst_n),
        .ivalid    (ivalid),
        .oready    (oready),
        .idata     (idata),
        .isel      (isel),
        .ibcast    (ibcast),
        .ovalid    (ovalid),
        .odata     (odata),
        .iready    (iready),
        .odrop_cnt (odrop_cnt)
    );

    dmux_stream_1n #(.DW(8), .NCH(3), .CW(2)) u_drop (
        .iclk      (iclk),
        .irst_n    (irst_n),
        .ivalid    (v3),
        .oready    (r3o),
        .idata     (d3),
        .isel      (s3),
        .ibcast    (b3),
        .ovalid    (ov3),
        .odata     (od3),
        .iready    (rdy3),
        .odrop_cnt (cnt3)
    );

    always #5 iclk = ~iclk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Input side: predict oready from the model and record accepted words.
    initial begin
        bit fr [4];
        bit exp_rdy;
        forever begin
            @(negedge iclk);
            if (!irst_n) begin
                for (int k = 0; k < 4; k++) begin
                    exp_q[k].delete();
                    held[k] = 1'b0;
                end
            end else begin
                for (int k = 0; k < 4; k++) begin
                    held[k] = (exp_q[k].size() != 0);
                    fr[k]   = !held[k] || iready[k];
                end
                if (ibcast) begin
                    exp_rdy = fr[0] && fr[1] && fr[2] && fr[3];
                end else begin
                    exp_rdy = fr[isel];
                end
                chk("oready", oready, exp_rdy);
                if (ivalid && exp_rdy) begin
                    if (ibcast) begin
                        for (int k = 0; k < 4; k++) exp_q[k].push_back(idata);
                    end else begin
                        exp_q[isel].push_back(idata);
                    end
                end
            end
        end
    end

    // Output side: every presented word must be the oldest outstanding one,
    // which also proves it holds steady while the consumer stalls.
    initial begin
        forever begin
            @(negedge iclk);
            #1;
            if (irst_n) begin
                for (int k = 0; k < 4; k++) begin
                    chk($sformatf("ch%0d_valid", k), ovalid[k], held[k]);
                    if (held[k]) begin
                        chk($sformatf("ch%0d_data", k), odata[k*8 +: 8], exp_q[k][0]);
                        if (iready[k]) void'(exp_q[k].pop_front());
                    end else begin
                        chk($sformatf("ch%0d_idle", k), odata[k*8 +: 8], 0);
                    end
                end
            end
        end
    end

    // Stimulus.
    initial begin
        logic [31:0] e;
        bit          took;
        int          sat;

        irst_n = 1'b0;
        ivalid = 1'b0; idata = '0; isel = '0; ibcast = 1'b0; iready = 4'b1111;
        v3 = 1'b0; d3 = '0; s3 = '0; b3 = 1'b0; rdy3 = 3'b111;

        // Reset and idle.
        repeat (3) @(posedge iclk);
        #2 irst_n = 1'b1;
        @(posedge iclk); #1; #1;
        chk("rst_ovalid", ovalid, 0);
        chk("rst_odata", odata, 0);
        chk("rst_drop", odrop_cnt, 0);
        chk("rst_ovalid3", ov3, 0);
        chk("rst_drop3", cnt3, 0);

        // Unicast sweep.
        for (int k = 0; k < 4; k++) begin
            @(posedge iclk); #1;
            ivalid = 1'b1; idata = 8'(8'hA0 + k); isel = 2'(k); ibcast = 1'b0;
            #1;
            chk("sweep_oready", oready, 1);
            if (k > 0) begin
                e = (32'hA0 + 32'(k) - 1) << (8 * (k - 1));
                chk("sweep_ovalid", ovalid, 4'b0001 << (k - 1));
                chk("sweep_odata", odata, e);
            end
        end
        @(posedge iclk); #1; ivalid = 1'b0; #1;
        chk("sweep_last_ovalid", ovalid, 4'b1000);
        chk("sweep_last_odata", odata, 32'hA300_0000);
        @(posedge iclk); #1; #1;
        chk("sweep_drained_ovalid", ovalid, 0);
        chk("sweep_drained_odata", odata, 0);

        // Back-pressure on channel 1.
        @(posedge iclk); #1;
        iready = 4'b1101; ivalid = 1'b1; idata = 8'h11; isel = 2'd1; #1;
        chk("bp_first_oready", oready, 1);
        @(posedge iclk); #1;
        idata = 8'h33; isel = 2'd0; #1;
        chk("bp_other_oready", oready, 1);
        chk("bp_hold_odata", odata, 32'h0000_1100);
        @(posedge iclk); #1;
        idata = 8'h22; isel = 2'd1; #1;
        chk("bp_stall_oready", oready, 0);
        chk("bp_both_ovalid", ovalid, 4'b0011);
        chk("bp_both_odata", odata, 32'h0000_1133);
        @(posedge iclk); #1; #1;
        chk("bp_still_oready", oready, 0);
        chk("bp_still_odata", odata, 32'h0000_1100);
        iready = 4'b1111; #1;
        chk("bp_release_oready", oready, 1);
        @(posedge iclk); #1;
        ivalid = 1'b0; #1;
        chk("bp_refill_ovalid", ovalid, 4'b0010);
        chk("bp_refill_odata", odata, 32'h0000_2200);
        @(posedge iclk); #1; #1;
        chk("bp_drained_ovalid", ovalid, 0);

        // Broadcast blocked by one stalled channel, then accepted.
        for (int k = 0; k < 4; k++) begin
            @(posedge iclk); #1;
            iready = 4'b0000; ivalid = 1'b1; idata = 8'(8'hB0 + k); isel = 2'(k); #1;
            chk("bc_fill_oready", oready, 1);
        end
        @(posedge iclk); #1;
        iready = 4'b1011; ibcast = 1'b1; idata = 8'h5C; isel = 2'd0; #1;
        chk("bc_block_oready", oready, 0);
        chk("bc_full_ovalid", ovalid, 4'b1111);
        chk("bc_full_odata", odata, 32'hB3B2_B1B0);
        @(posedge iclk); #1; #1;
        chk("bc_partial_ovalid", ovalid, 4'b0100);
        chk("bc_partial_odata", odata, 32'h00B2_0000);
        chk("bc_partial_oready", oready, 0);
        iready = 4'b1111; #1;
        chk("bc_accept_oready", oready, 1);
        @(posedge iclk); #1;
        ivalid = 1'b0; ibcast = 1'b0; #1;
        chk("bc_ovalid", ovalid, 4'b1111);
        chk("bc_odata", odata, 32'h5C5C_5C5C);
        chk("bc_drop", odrop_cnt, 0);
        @(posedge iclk); #1; #1;
        chk("bc_drained_ovalid", ovalid, 0);

        // Reset while a word is held on channel 2.
        @(posedge iclk); #1;
        iready = 4'b0000; ivalid = 1'b1; idata = 8'h42; isel = 2'd2; #1;
        @(posedge iclk); #1;
        ivalid = 1'b0; #1;
        chk("mid_held_ovalid", ovalid, 4'b0100);
        #1 irst_n = 1'b0;
        #1;
        chk("mid_rst_ovalid", ovalid, 0);
        chk("mid_rst_odata", odata, 0);
        chk("mid_rst_drop", odrop_cnt, 0);
        iready = 4'b1111;
        repeat (2) @(posedge iclk);
        #2 irst_n = 1'b1;

        // Drops and saturation on the 3-channel instance.
        sat = 0;
        for (int n = 0; n < 5; n++) begin
            @(posedge iclk); #1;
            v3 = 1'b1; s3 = 2'd3; d3 = 8'(n); b3 = 1'b0; #1;
            chk("drop_oready", r3o, 1);
            chk("drop_ovalid", ov3, 0);
            chk("drop_cnt", cnt3, sat);
            sat = (n + 1 > 3) ? 3 : n + 1;
        end
        @(posedge iclk); #1;
        s3 = 2'd2; d3 = 8'h9A; #1;
        chk("drop_final_cnt", cnt3, sat);
        chk("u3_uni_oready", r3o, 1);
        @(posedge iclk); #1;
        b3 = 1'b1; d3 = 8'h77; #1;
        chk("u3_uni_ovalid", ov3, 3'b100);
        chk("u3_uni_odata", od3, 24'h9A_0000);
        chk("u3_uni_cnt", cnt3, sat);
        chk("u3_bc_oready", r3o, 1);
        @(posedge iclk); #1;
        v3 = 1'b0; b3 = 1'b0; #1;
        chk("u3_bc_ovalid", ov3, 3'b111);
        chk("u3_bc_odata", od3, 24'h77_7777);
        chk("u3_bc_cnt", cnt3, sat);

        // Random soak; the producer holds its word until it is taken.
        for (int c = 0; c < 10000; c++) begin
            @(negedge iclk);
            took = ivalid && oready;
            @(posedge iclk); #1;
            if (!ivalid || took) begin
                ivalid = ($urandom_range(0, 3) != 0);
                idata  = 8'($urandom);
                isel   = 2'($urandom_range(0, 3));
                ibcast = ($urandom_range(0, 7) == 0);
            end
            iready = 4'($urandom);
        end

        // Drain and confirm everything left the block.
        @(negedge iclk);
        took = ivalid && oready;
        @(posedge iclk); #1;
        ivalid = 1'b0; ibcast = 1'b0; iready = 4'b1111;
        repeat (4) @(posedge iclk);
        #2;
        chk("end_ovalid", ovalid, 0);
        chk("end_odata", odata, 0);
        chk("end_drop", odrop_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmux_stream_1n.md
Name: dmux_stream_1n

Overview:
- Parametrised, registered 1-to-NCH demultiplexer for valid/ready streams; successor to the combinational 1-to-4 demux.
- Routes each input word either to one selected output channel (unicast) or to all channels (broadcast).
- Each channel owns a one-entry output register, giving one cycle of latency and full throughput under back-pressure.
- Placed between a single producer and NCH independent consumers.

Parameters:
- DW, 8, data width in bits (1..64).
- NCH, 4, number of output channels (2..16); SW = clog2(NCH) is derived locally, not overridable.
- CW, 8, width of the saturating drop counter (2..16).

Ports:
- iclk  input  1  clock, rising edge.
- irst_n  input  1  asynchronous active-low reset.
- ivalid  input  1  input word valid.
- oready  output  1  block accepts the input word this cycle.
- idata  input  DW  input word.
- isel  input  SW  target channel, used in unicast only.
- ibcast  input  1  1 = broadcast to all channels, 0 = unicast.
- ovalid  output  NCH  per-channel output valid.
- odata  output  NCH*DW  channel k occupies bits [k*DW +: DW].
- iready  input  NCH  per-channel consumer ready.
- odrop_cnt  output  CW  count of words dropped because isel >= NCH; saturates.

Behaviour:
- Single clock domain; all state on iclk rising edge with async clear on irst_n.
- Reset state: ovalid = 0, odata = 0, odrop_cnt = 0. Reset asserted mid-operation discards held words immediately and does not count them as drops.
- Channel k is "free" when ovalid[k] = 0 or iready[k] = 1.
- oready is combinational from iready, ovalid, isel and ibcast:
  - unicast, isel < NCH: oready = free[isel].
  - unicast, isel >= NCH: oready = 1.
  - broadcast: oready = AND of free[k] over all k.
- Transfer occurs when ivalid & oready.
- Unicast transfer, isel < NCH: next cycle ovalid[isel] = 1 and odata[isel] = idata; other channels are unaffected.
- Unicast transfer, isel >= NCH (only possible when NCH is not a power of 2): word is dropped, odrop_cnt += 1, stopping at 2^CW-1; no ovalid changes.
- Broadcast transfer: next cycle every channel has ovalid = 1 and odata = idata; isel is ignored and odrop_cnt is unchanged.
- Drain: when ovalid[k] & iready[k] and channel k is not refilled in the same cycle, ovalid[k] goes to 0 and odata[k] is cleared to 0 on the next edge. Idle channels always read 0.
- Simultaneous drain and refill of channel k: new word loaded, ovalid[k] stays 1, no bubble. Back-to-back throughput is one word per cycle per channel.
- While ovalid[k] = 1 and iready[k] = 0, odata[k] holds stable.
- Latency: word accepted at edge n is visible on odata/ovalid after edge n; minimum one cycle, no combinational data path from idata to odata.
- Input protocol the block relies on: the producer holds ivalid, idata, isel and ibcast stable until oready. A violation is not detected; the block acts on the values present in the transfer cycle.
- No ordering guarantee across channels; within a channel, order is preserved.

Test Plan:
- Reset and idle: hold irst_n = 0, then release with ivalid = 0 -> ovalid = 4'b0000, odata = 0, odrop_cnt = 0. Assert irst_n = 0 while ovalid[2] = 1 -> ovalid[2] clears immediately and odrop_cnt stays 0.
- Unicast sweep (NCH=4, DW=8), iready = 4'b1111: send 0xA0, 0xA1, 0xA2, 0xA3 with isel 0, 1, 2, 3 on consecutive cycles -> each word appears exactly one cycle later on its channel only, oready stays 1, and each channel returns to ovalid = 0 / odata = 0 the cycle after it drains.
- Back-pressure: iready[1] = 0, send 0x11 then 0x22 to isel = 1 -> 0x11 is held on channel 1, oready = 0 on the second word; raise iready[1] -> 0x22 loads on the same edge that 0x11 drains, with no bubble. A concurrent word to isel = 0 is still accepted while channel 1 is stalled.
- Broadcast: iready = 4'b1011 with all channels full, ibcast = 1, idata = 0x5C -> oready = 0; set iready = 4'b1111 -> accepted, next cycle ovalid = 4'b1111 and all odata slices = 0x5C.
- Drop and saturate (NCH=3, CW=2): send 5 unicast words with isel = 3 -> all accepted, ovalid never set, odrop_cnt reads 1, 2, 3, 3, 3.
- Random soak: random ivalid/iready/isel/ibcast for 10k cycles, checked against a scoreboard model -> no loss, duplication or reordering per channel, and odata stable whenever ovalid & !iready.
